// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared encodings and defaults for the register writeback unit
package wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_REGS   = 32;

  // RY source select; the reserved code behaves like the ALU path
  typedef enum logic [1:0] {
    SEL_ALU = 2'b00,
    SEL_MEM = 2'b01,
    SEL_RA  = 2'b10,
    SEL_RSV = 2'b11
  } wb_sel_e;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - small synchronous FIFO with occupancy count and flush
module wb_fifo #(
  parameter int  WIDTH = 37,
  parameter int  DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a full queue may still take a push when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // pointer and occupancy bookkeeping; flush empties the queue at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // entry storage; contents need no reset since count guards every read
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/reg_writeback_unit.sv
// rtl/reg_writeback_unit.sv - queued register-file writeback with pending scoreboard
module reg_writeback_unit
  import wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wb_valid,
  output logic                wb_ready,
  input  logic [ADDR_W-1:0]   wb_rdst,
  input  logic [1:0]          wb_sel,
  input  logic [DATA_W-1:0]   wb_alu,
  input  logic [DATA_W-1:0]   wb_mem,
  input  logic [DATA_W-1:0]   wb_ra,
  input  logic                claim_valid,
  input  logic [ADDR_W-1:0]   claim_rdst,
  input  logic                hold,
  input  logic                flush,
  output logic [ADDR_W-1:0]   Rdst,
  output logic [DATA_W-1:0]   RY,
  output logic                RF_WRITE,
  output logic [NUM_REGS-1:0] pending,
  output logic                err
);

  localparam int ENT_W = ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [NUM_REGS-1:0] ONE = {{(NUM_REGS - 1){1'b0}}, 1'b1};

  logic [DATA_W-1:0]   sel_data;
  logic [ENT_W-1:0]    fifo_dout;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_empty;
  logic                accept;
  logic                bypass;
  logic                wr_valid;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_rdst;
  logic [DATA_W-1:0]   wr_data;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] claim_mask;
  logic [NUM_REGS-1:0] push_mask;
  logic                claim_err;
  logic                push_err;

  // RY source chosen at acceptance so the queue holds final write data
  always_comb begin
    sel_data = wb_alu;
    case (wb_sel_e'(wb_sel))
      SEL_MEM: sel_data = wb_mem;
      SEL_RA:  sel_data = wb_ra;
      default: sel_data = wb_alu;
    endcase
  end

  // ready depends only on registered occupancy
  assign wb_ready = (fifo_count < CNT_W'(DEPTH));
  assign accept   = wb_valid & wb_ready & ~flush;
  // an empty queue forwards the new result straight to the write stage
  assign bypass   = accept & fifo_empty & ~hold;
  assign wr_valid = ~flush & ~hold & (~fifo_empty | bypass);
  assign {wr_rdst, wr_data} = fifo_empty ? {wb_rdst, sel_data} : fifo_dout;
  // register 0 is never written
  assign wr_en    = wr_valid & (wr_rdst != '0);

  wb_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept & ~bypass),
    .pop   (~hold & ~flush),
    .flush (flush),
    .din   ({wb_rdst, sel_data}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign clr_mask   = wr_en ? (ONE << wr_rdst) : '0;
  assign claim_mask = (claim_valid && !flush && claim_rdst != '0) ? (ONE << claim_rdst) : '0;
  assign push_mask  = ONE << wb_rdst;
  // reclaiming a register that retires this very cycle is legal
  assign claim_err  = |(claim_mask & pending & ~clr_mask);
  assign push_err   = accept & (wb_rdst != '0) & ~|(pending & push_mask);

  // write port registers hold their last value between writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RF_WRITE <= 1'b0;
      Rdst     <= '0;
      RY       <= '0;
    end else begin
      RF_WRITE <= wr_en;
      if (wr_en) begin
        Rdst <= wr_rdst;
        RY   <= wr_data;
      end
    end
  end

  // scoreboard: retire clears, claim sets (set wins), bit 0 stays low; err is sticky
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      err     <= 1'b0;
    end else begin
      if (flush) pending <= '0;
      else       pending <= ((pending & ~clr_mask) | claim_mask) & ~ONE;
      if (claim_err || push_err) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_writeback_unit.sv
// tb/tb_reg_writeback_unit.sv - scoreboard bench for reg_writeback_unit
module tb_reg_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rdst;
  logic [1:0]  wb_sel;
  logic [31:0] wb_alu;
  logic [31:0] wb_mem;
  logic [31:0] wb_ra;
  logic        claim_valid;
  logic [4:0]  claim_rdst;
  logic        hold;
  logic        flush;
  logic [4:0]  Rdst;
  logic [31:0] RY;
  logic        RF_WRITE;
  logic [31:0] pending;
  logic        err;

  int          checks = 0;
  int          errors = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_e;

  reg_writeback_unit #(.DATA_W(32), .ADDR_W(5), .DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_rdst     (wb_rdst),
    .wb_sel      (wb_sel),
    .wb_alu      (wb_alu),
    .wb_mem      (wb_mem),
    .wb_ra       (wb_ra),
    .claim_valid (claim_valid),
    .claim_rdst  (claim_rdst),
    .hold        (hold),
    .flush       (flush),
    .Rdst        (Rdst),
    .RY          (RY),
    .RF_WRITE    (RF_WRITE),
    .pending     (pending),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic claim(input logic [4:0] r);
    claim_valid = 1'b1;
    claim_rdst  = r;
    cyc();
    claim_valid = 1'b0;
  endtask

  task automatic offer(input logic [4:0] r, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] m, input logic [31:0] rv);
    wb_valid = 1'b1;
    wb_rdst  = r;
    wb_sel   = s;
    wb_alu   = a;
    wb_mem   = m;
    wb_ra    = rv;
  endtask

  // monitor: every register-file write must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n === 1'b1 && RF_WRITE === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: Rdst=%0d RY=0x%0h, required no write", Rdst, RY);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_rdst", {27'd0, Rdst}, {27'd0, mon_e[36:32]});
        chk("write_data", RY, mon_e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; wb_valid = 1'b0; wb_rdst = '0; wb_sel = '0;
    wb_alu = '0; wb_mem = '0; wb_ra = '0; claim_valid = 1'b0;
    claim_rdst = '0; hold = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_write", {31'd0, RF_WRITE}, 32'd0);
    chk("rst_rdst", {27'd0, Rdst}, 32'd0);
    chk("rst_ry", RY, 32'd0);
    chk("rst_pending", pending, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("rst_ready", {31'd0, wb_ready}, 32'd1);

    // claim r5, write ALU result, one-cycle latency and pending clears
    claim(5'd5);
    chk("claim5_pending", pending, 32'h0000_0020);
    offer(5'd5, 2'b00, 32'h1234, 32'hAAAA, 32'hBBBB);
    exp_q.push_back({5'd5, 32'h0000_1234});
    cyc();
    wb_valid = 1'b0;
    chk("w5_rf_write", {31'd0, RF_WRITE}, 32'd1);
    chk("w5_pending", pending, 32'd0);
    chk("w5_err", {31'd0, err}, 32'd0);
    cyc();
    chk("w5_single_pulse", {31'd0, RF_WRITE}, 32'd0);

    // back-to-back writes, one per cycle
    claim(5'd10);
    claim(5'd11);
    offer(5'd10, 2'b00, 32'hA0A0_0010, 32'h0, 32'h0);
    exp_q.push_back({5'd10, 32'hA0A0_0010});
    cyc();
    chk("b2b_first", {31'd0, RF_WRITE}, 32'd1);
    offer(5'd11, 2'b10, 32'h0, 32'h0, 32'hB0B0_0011);
    exp_q.push_back({5'd11, 32'hB0B0_0011});
    cyc();
    wb_valid = 1'b0;
    chk("b2b_second", {31'd0, RF_WRITE}, 32'd1);

    // hold: two entries fill the queue, third waits, then FIFO-order drain
    claim(5'd1);
    claim(5'd2);
    claim(5'd3);
    hold = 1'b1;
    offer(5'd1, 2'b01, 32'h0, 32'h1111_0001, 32'h0);
    exp_q.push_back({5'd1, 32'h1111_0001});
    cyc();
    offer(5'd2, 2'b10, 32'h0, 32'h0, 32'h2222_0002);
    exp_q.push_back({5'd2, 32'h2222_0002});
    cyc();
    chk("hold_ready_low", {31'd0, wb_ready}, 32'd0);
    chk("hold_no_write", {31'd0, RF_WRITE}, 32'd0);
    offer(5'd3, 2'b11, 32'h3333_0003, 32'hDEAD_0003, 32'h0);
    cyc();
    chk("hold_third_waits", {31'd0, wb_ready}, 32'd0);
    chk("hold_still_no_write", {31'd0, RF_WRITE}, 32'd0);
    hold = 1'b0;
    cyc();
    chk("drain_r1_we", {31'd0, RF_WRITE}, 32'd1);
    chk("drain_r1_rdst", {27'd0, Rdst}, 32'd1);
    chk("drain_ready", {31'd0, wb_ready}, 32'd1);
    exp_q.push_back({5'd3, 32'h3333_0003});
    cyc();
    wb_valid = 1'b0;
    chk("drain_r2_rdst", {27'd0, Rdst}, 32'd2);
    cyc();
    chk("drain_r3_we", {31'd0, RF_WRITE}, 32'd1);
    chk("drain_r3_rdst", {27'd0, Rdst}, 32'd3);
    cyc();
    chk("drain_done", {31'd0, RF_WRITE}, 32'd0);
    chk("drain_pending", pending, 32'd0);

    // write to r0 is accepted but suppressed; outputs retain last write
    offer(5'd0, 2'b01, 32'h0, 32'h0000_DEAD, 32'h0);
    cyc();
    wb_valid = 1'b0;
    chk("r0_no_write", {31'd0, RF_WRITE}, 32'd0);
    chk("r0_err", {31'd0, err}, 32'd0);
    chk("retain_rdst", {27'd0, Rdst}, 32'd3);
    chk("retain_ry", RY, 32'h3333_0003);
    cyc();
    chk("r0_still_no_write", {31'd0, RF_WRITE}, 32'd0);

    // claim in the same cycle as retirement of that register: set wins
    claim(5'd12);
    offer(5'd12, 2'b00, 32'h0000_C0C0, 32'h0, 32'h0);
    exp_q.push_back({5'd12, 32'h0000_C0C0});
    claim_valid = 1'b1;
    claim_rdst  = 5'd12;
    cyc();
    claim_valid = 1'b0;
    wb_valid    = 1'b0;
    chk("setwins_we", {31'd0, RF_WRITE}, 32'd1);
    chk("setwins_pending", pending, 32'h0000_1000);
    chk("setwins_err", {31'd0, err}, 32'd0);
    offer(5'd12, 2'b00, 32'h0000_C1C1, 32'h0, 32'h0);
    exp_q.push_back({5'd12, 32'h0000_C1C1});
    cyc();
    wb_valid = 1'b0;
    chk("setwins_clear", pending, 32'd0);

    // flush with two queued entries
    claim(5'd4);
    claim(5'd6);
    hold = 1'b1;
    offer(5'd4, 2'b00, 32'h4444, 32'h0, 32'h0);
    cyc();
    offer(5'd6, 2'b00, 32'h6666, 32'h0, 32'h0);
    cyc();
    wb_valid = 1'b0;
    chk("flush_full", {31'd0, wb_ready}, 32'd0);
    chk("flush_pre_pending", pending, 32'h0000_0050);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    hold  = 1'b0;
    chk("flush_no_write", {31'd0, RF_WRITE}, 32'd0);
    chk("flush_pending", pending, 32'd0);
    chk("flush_empty", {31'd0, wb_ready}, 32'd1);
    cyc();
    chk("flush_nothing_left", {31'd0, RF_WRITE}, 32'd0);
    chk("flush_err", {31'd0, err}, 32'd0);

    // double claim of r7 raises a sticky error
    claim(5'd7);
    claim(5'd7);
    chk("dup_claim_err", {31'd0, err}, 32'd1);
    repeat (3) cyc();
    chk("err_sticky", {31'd0, err}, 32'd1);

    // asynchronous reset while the queue is full
    claim(5'd8);
    claim(5'd9);
    hold = 1'b1;
    offer(5'd8, 2'b00, 32'h8888, 32'h0, 32'h0);
    cyc();
    offer(5'd9, 2'b00, 32'h9999, 32'h0, 32'h0);
    cyc();
    wb_valid = 1'b0;
    chk("arst_full", {31'd0, wb_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rf_write", {31'd0, RF_WRITE}, 32'd0);
    chk("arst_rdst", {27'd0, Rdst}, 32'd0);
    chk("arst_ry", RY, 32'd0);
    chk("arst_pending", pending, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    hold = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_rst_no_write", {31'd0, RF_WRITE}, 32'd0);
    end
    chk("post_rst_ready", {31'd0, wb_ready}, 32'd1);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_writeback_unit.md
REG_WRITEBACK_UNIT -- requirements
Module: reg_writeback_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width (32 registers).
REQ-003 SHALL have parameter DEPTH, default 2, writeback queue entries.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port wb_valid  in  1  execute stage offers a result.
REQ-007 SHALL have port wb_ready  out  1  queue can accept; transfer when wb_valid&wb_ready.
REQ-008 SHALL have port wb_rdst  in  ADDR_W  destination register of offered result.
REQ-009 SHALL have port wb_sel  in  2  RY source: 00 ALU, 01 memory, 10 return address, 11 reserved (treated as 00).
REQ-010 SHALL have ports wb_alu, wb_mem, wb_ra  in  DATA_W each  candidate results.
REQ-011 SHALL have port claim_valid  in  1  decode reserves a destination this cycle.
REQ-012 SHALL have port claim_rdst  in  ADDR_W  register being reserved.
REQ-013 SHALL have port hold  in  1  freeze register-file writes (debug/stall).
REQ-014 SHALL have port flush  in  1  discard all queued and pending writes.
REQ-015 SHALL have port Rdst  out  ADDR_W  register-file write address.
REQ-016 SHALL have port RY  out  DATA_W  register-file write data.
REQ-017 SHALL have port RF_WRITE  out  1  register-file write enable, one cycle per write.
REQ-018 SHALL have port pending  out  32  scoreboard; bit r set while register r awaits writeback.
REQ-019 SHALL have port err  out  1  sticky protocol-violation flag.

Function
REQ-020 SHALL select RY source by wb_sel at acceptance and store {rdst, data} in a FIFO of DEPTH entries.
REQ-021 SHALL drive wb_ready = (count < DEPTH), with no combinational path from wb_valid or hold.
REQ-022 SHALL, when queue non-empty and hold=0, pop head and register Rdst/RY with RF_WRITE=1 on next cycle; otherwise RF_WRITE=0.
REQ-023 SHALL give latency of one cycle from acceptance (empty queue, hold=0) to RF_WRITE, sustaining one write per cycle.
REQ-024 SHALL allow push and pop in the same cycle when full, leaving count unchanged; wb_ready stays low that cycle.
REQ-025 SHALL accept writes to register 0 but suppress them: popped entry with rdst=0 yields RF_WRITE=0.
REQ-026 SHALL retain Rdst/RY values when RF_WRITE=0.
REQ-027 SHALL set pending[claim_rdst] on claim_valid when claim_rdst!=0; pending[0] is constant 0.
REQ-028 SHALL clear pending[Rdst] in the cycle RF_WRITE=1; simultaneous claim of same register: set wins.
REQ-029 SHALL set err on claim of an already-pending register (other than REQ-028 case) or wb_valid&wb_ready with wb_rdst!=0 not pending; err cleared only by reset.
REQ-030 SHALL on flush empty the queue, clear pending, force RF_WRITE=0 next cycle, drop same-cycle push and claim; flush overrides hold.
REQ-031 SHALL on hold keep queue contents, accept pushes while space remains, and resume popping in FIFO order when hold falls.

Reset
REQ-032 SHALL on rst_n low, immediately and independent of clk, set count=0, RF_WRITE=0, Rdst=0, RY=0, pending=0, err=0, wb_ready=1 after release.
REQ-033 SHALL discard any in-flight write on reset mid-operation; no RF_WRITE pulse after release until new acceptance.

Structure
REQ-034 SHALL place wb_sel encodings, DATA_W/ADDR_W defaults and register count in shared package wb_pkg.
REQ-035 SHALL implement the queue as sub-module wb_fifo (parameterised width/depth, count, push/pop, flush).

Verification
REQ-036 SHALL cover claim r5, push rdst=5 sel=00 alu=0x1234 -> next cycle RF_WRITE=1, Rdst=5, RY=0x1234, pending[5] clears.
REQ-037 SHALL cover hold=1 with pushes r1,r2,r3 -> wb_ready low after two, third waits; hold=0 -> writes r1,r2,r3 in consecutive cycles.
REQ-038 SHALL cover push rdst=0 sel=01 mem=0xDEAD -> RF_WRITE stays 0, err stays 0.
REQ-039 SHALL cover claim r7 twice with no writeback -> err=1 and remains 1 until rst_n low.
REQ-040 SHALL cover two queued entries then flush -> RF_WRITE=0 next cycle, pending=0, count=0.
REQ-041 SHALL cover rst_n low while queue full -> outputs zero immediately, no RF_WRITE after release.
